multicycle_control: RTL and testbench

Multicycle MIPS control sequencer: the stateful successor of the single-cycle decode-only control unit. Latches the fetched instruction's opcode/funct, steps FETCH→DECODE→EXEC→MEM→WB per instruction class, and drives per-state datapath strobes. Memory requests are handshaked on `ihit`/`dhit`, with a parametrised stall timeout. Sits between the multicycle datapath and the memory/cache interface.

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/control_decode.sv | 48 ++++
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction encodings, multicycle sequencer states,
// PC source select and the static control fields decoded from an instruction.
package cpu_types_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
      OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
      OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT  = 6'h3F
   } opcode_t;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20,
      FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
      FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
      FN_SLTU = 6'h2B
   } funct_t;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR
   } ctrl_state_t;

   typedef enum logic [1:0] {
      PCSEL_NEXT, PCSEL_BRANCH, PCSEL_JUMP, PCSEL_REG
   } pcsel_t;

   typedef struct packed {
      logic regDst;
      logic pcToReg;
      logic immToReg;
      logic memToReg;
      logic extOp;
      logic shamToAlu;
      logic immToAlu;
   } ctrl_fields_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: static datapath control fields plus an
// illegal flag for unrecognised opcodes or R-type functs.
module control_decode
   import cpu_types_pkg::*;
(
   input  opcode_t      opcode,
   input  funct_t       funct,
   output ctrl_fields_t fields,
   output logic         illegal
);

   always_comb begin
      fields  = '0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            fields.regDst = 1'b1;
            case (funct)
               FN_SLL, FN_SRL: fields.shamToAlu = 1'b1;
               FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
               FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ;
               default: illegal = 1'b1;
            endcase
         end
         OP_J, OP_HALT: ;
         OP_JAL: fields.pcToReg = 1'b1;
         OP_BEQ, OP_BNE: fields.extOp = 1'b1;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            fields.extOp    = 1'b1;
            fields.immToAlu = 1'b1;
         end
         // Logical immediates are zero-extended.
         OP_ANDI, OP_ORI, OP_XORI: fields.immToAlu = 1'b1;
         OP_LUI: fields.immToReg = 1'b1;
         OP_LW: begin
            fields.extOp    = 1'b1;
            fields.immToAlu = 1'b1;
            fields.memToReg = 1'b1;
         end
         OP_SW: begin
            fields.extOp    = 1'b1;
            fields.immToAlu = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: instruction register, FETCH..WB state
// machine with ihit/dhit handshakes and a memory-wait timeout into ERROR.
module multicycle_control
   import cpu_types_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  opcode_t     opcode,
   input  funct_t      funct,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        zero,
   output logic        iREN,
   output logic        dREN,
   output logic        dWEN,
   output logic        IrWr,
   output logic        PcWr,
   output pcsel_t      PcSel,
   output logic        RegWr,
   output logic        RegDst,
   output logic        PcToReg,
   output logic        ImmToReg,
   output logic        MemToReg,
   output logic        ExtOp,
   output logic        ShamToAlu,
   output logic        ImmToAlu,
   output logic        Halt,
   output logic        Err,
   output ctrl_state_t dbgState
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   ctrl_state_t   state, nextState;
   opcode_t       irOp;
   funct_t        irFunct;
   logic [CW-1:0] waitCnt;
   ctrl_fields_t  fields;
   logic          illegal;
   logic          timedOut;

   control_decode uDecode (
      .opcode  (irOp),
      .funct   (irFunct),
      .fields  (fields),
      .illegal (illegal)
   );

   // A hit in the same cycle takes priority over the timeout.
   assign timedOut = (MEM_TIMEOUT != 0) && (waitCnt == CW'(MEM_TIMEOUT));

   // Strobes depend on the hit/zero inputs of the current cycle, so they are
   // decoded alongside the next state rather than registered.
   always_comb begin
      nextState = state;
      iREN      = 1'b0;
      dREN      = 1'b0;
      dWEN      = 1'b0;
      IrWr      = 1'b0;
      PcWr      = 1'b0;
      PcSel     = PCSEL_NEXT;
      RegWr     = 1'b0;
      case (state)
         FETCH: begin
            iREN = 1'b1;
            if (ihit) begin
               IrWr      = 1'b1;
               PcWr      = 1'b1;
               nextState = DECODE;
            end else if (timedOut) begin
               nextState = ERROR;
            end
         end
         DECODE: begin
            if (irOp == OP_J || irOp == OP_JAL) begin
               PcWr      = 1'b1;
               PcSel     = PCSEL_JUMP;
               RegWr     = (irOp == OP_JAL);
               nextState = FETCH;
            end else if (illegal) begin
               nextState = ERROR;
            end else if (irOp == OP_RTYPE && irFunct == FN_JR) begin
               PcWr      = 1'b1;
               PcSel     = PCSEL_REG;
               nextState = FETCH;
            end else if (irOp == OP_HALT) begin
               nextState = HALT;
            end else begin
               nextState = EXEC;
            end
         end
         EXEC: begin
            if (irOp == OP_BEQ || irOp == OP_BNE) begin
               PcWr      = (irOp == OP_BEQ) ? zero : !zero;
               PcSel     = PCSEL_BRANCH;
               nextState = FETCH;
            end else if (irOp == OP_LW || irOp == OP_SW) begin
               nextState = MEM;
            end else begin
               nextState = WB;
            end
         end
         MEM: begin
            dREN = (irOp == OP_LW);
            dWEN = (irOp == OP_SW);
            if (dhit)          nextState = (irOp == OP_LW) ? WB : FETCH;
            else if (timedOut) nextState = ERROR;
         end
         WB: begin
            RegWr     = 1'b1;
            nextState = FETCH;
         end
         default: nextState = state;
      endcase
      if (RST) begin
         iREN  = 1'b0;
         dREN  = 1'b0;
         dWEN  = 1'b0;
         IrWr  = 1'b0;
         PcWr  = 1'b0;
         PcSel = PCSEL_NEXT;
         RegWr = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= FETCH;
         irOp    <= OP_RTYPE;
         irFunct <= FN_SLL;
         waitCnt <= '0;
      end else begin
         state <= nextState;
         if (IrWr) begin
            irOp    <= opcode;
            irFunct <= funct;
         end
         if (nextState != state)
            waitCnt <= '0;
         else if (state == FETCH || state == MEM)
            waitCnt <= waitCnt + CW'(1);
      end
   end

   // The zeroed IR decodes as SLL; mask it so reset drives every output low.
   assign RegDst    = fields.regDst    & ~RST;
   assign PcToReg   = fields.pcToReg   & ~RST;
   assign ImmToReg  = fields.immToReg  & ~RST;
   assign MemToReg  = fields.memToReg  & ~RST;
   assign ExtOp     = fields.extOp     & ~RST;
   assign ShamToAlu = fields.shamToAlu & ~RST;
   assign ImmToAlu  = fields.immToAlu  & ~RST;
   assign Halt      = (state == HALT) || (state == ERROR);
   assign Err       = (state == ERROR);
   assign dbgState  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded by a reference
// model into expected per-cycle outputs; a monitor checks them on the falling edge.
module tb_multicycle_control;
   import cpu_types_pkg::*;

   localparam int TO = 4;
   localparam int W  = 20;
   // {iREN, dREN, dWEN, IrWr, PcWr, PcSel[1:0], RegWr}
   localparam logic [7:0] S_NONE = 8'b0000_0000;
   localparam logic [7:0] S_IREQ = 8'b1000_0000;
   localparam logic [7:0] S_FHIT = 8'b1001_1000;
   localparam logic [7:0] S_DREQ = 8'b0100_0000;
   localparam logic [7:0] S_WREQ = 8'b0010_0000;
   localparam logic [7:0] S_WB   = 8'b0000_0001;
   localparam logic [7:0] S_J    = 8'b0000_1100;
   localparam logic [7:0] S_JAL  = 8'b0000_1101;
   localparam logic [7:0] S_JR   = 8'b0000_1110;
   localparam logic [7:0] S_BRT  = 8'b0000_1010;
   localparam logic [7:0] S_BRN  = 8'b0000_0010;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   opcode_t     opcode = OP_RTYPE;
   funct_t      funct = FN_SLL;
   logic        ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
   logic        iREN, dREN, dWEN, IrWr, PcWr, RegWr;
   logic        RegDst, PcToReg, ImmToReg, MemToReg, ExtOp, ShamToAlu, ImmToAlu;
   logic        Halt, Err;
   pcsel_t      PcSel;
   ctrl_state_t dbgState;

   typedef struct {
      logic         rst;
      logic         ih;
      logic         dh;
      logic         z;
      logic [5:0]   op;
      logic [5:0]   fn;
      logic [W-1:0] e;
   } cyc_t;

   cyc_t         plan[$];
   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [6:0]   cur_stat = 7'b0;
   logic         force_ih = 1'b0;

   always #5 CLK = ~CLK;

   multicycle_control #(.MEM_TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct),
      .ihit(ihit), .dhit(dhit), .zero(zero),
      .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IrWr(IrWr), .PcWr(PcWr),
      .PcSel(PcSel), .RegWr(RegWr), .RegDst(RegDst), .PcToReg(PcToReg),
      .ImmToReg(ImmToReg), .MemToReg(MemToReg), .ExtOp(ExtOp),
      .ShamToAlu(ShamToAlu), .ImmToAlu(ImmToAlu), .Halt(Halt), .Err(Err),
      .dbgState(dbgState)
   );

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rnd6();
      return 6'($urandom_range(0, 63));
   endfunction

   // Static fields as a table: {RegDst,PcToReg,ImmToReg,MemToReg,ExtOp,ShamToAlu,ImmToAlu}
   function automatic logic [6:0] stat_of(logic [5:0] op, logic [5:0] fn);
      logic [6:0] s;
      s = 7'b0;
      s[6] = (op == OP_RTYPE);
      s[5] = (op == OP_JAL);
      s[4] = (op == OP_LUI);
      s[3] = (op == OP_LW);
      s[2] = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_BNE};
      s[1] = (op == OP_RTYPE) && (fn inside {FN_SLL, FN_SRL});
      s[0] = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
                        OP_LW, OP_SW};
      return s;
   endfunction

   function automatic logic legal_of(logic [5:0] op, logic [5:0] fn);
      if (!(op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
                       OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_HALT}))
         return 1'b0;
      if (op == OP_RTYPE)
         return fn inside {FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
                           FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
      return 1'b1;
   endfunction

   task automatic add(input ctrl_state_t s, input logic [7:0] strb, input logic h,
                      input logic er, input logic ih, input logic dh, input logic z,
                      input logic [5:0] op, input logic [5:0] fn);
      cyc_t c;
      c.rst = 1'b0; c.ih = ih; c.dh = dh; c.z = z; c.op = op; c.fn = fn;
      c.e = {s, strb, h, er, cur_stat};
      plan.push_back(c);
   endtask

   // A cycle with no pending request: hits and bus contents are don't-care noise.
   task automatic add_n(input ctrl_state_t s, input logic [7:0] strb);
      add(s, strb, 1'b0, 1'b0, force_ih ? 1'b1 : rnd1(), rnd1(), rnd1(), rnd6(), rnd6());
   endtask

   task automatic add_tail(input ctrl_state_t s);
      for (int i = 0; i < 5; i++)
         add(s, S_NONE, 1'b1, s == ERROR, (i % 2 == 0) ? 1'b1 : rnd1(), rnd1(), rnd1(),
             rnd6(), rnd6());
   endtask

   task automatic add_reset(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c.rst = 1'b1; c.ih = rnd1(); c.dh = rnd1(); c.z = rnd1(); c.op = rnd6(); c.fn = rnd6();
         c.e = {FETCH, 17'b0};
         plan.push_back(c);
      end
      cur_stat = stat_of(OP_RTYPE, FN_SLL);
   endtask

   // Reference model: expected cycle sequence for one instruction given its
   // instruction-fetch wait (iw) and data wait (dw) in cycles.
   task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int iw, input int dw);
      logic [7:0] req;
      for (int i = 0; i < iw && i <= TO; i++)
         add(FETCH, S_IREQ, 1'b0, 1'b0, 1'b0, rnd1(), rnd1(), rnd6(), rnd6());
      if (iw > TO) begin
         add_tail(ERROR);
         return;
      end
      add(FETCH, S_FHIT, 1'b0, 1'b0, 1'b1, rnd1(), rnd1(), op, fn);
      cur_stat = stat_of(op, fn);
      if (!legal_of(op, fn)) begin
         add_n(DECODE, S_NONE);
         add_tail(ERROR);
         return;
      end
      if (op == OP_HALT) begin
         add_n(DECODE, S_NONE);
         add_tail(HALT);
         return;
      end
      if (op == OP_J)   begin add_n(DECODE, S_J);   return; end
      if (op == OP_JAL) begin add_n(DECODE, S_JAL); return; end
      if (op == OP_RTYPE && fn == FN_JR) begin add_n(DECODE, S_JR); return; end
      add_n(DECODE, S_NONE);
      if (op == OP_BEQ || op == OP_BNE) begin
         add(EXEC, (((op == OP_BEQ) ? z : !z) ? S_BRT : S_BRN), 1'b0, 1'b0,
             force_ih ? 1'b1 : rnd1(), rnd1(), z, rnd6(), rnd6());
         return;
      end
      add_n(EXEC, S_NONE);
      if (op == OP_LW || op == OP_SW) begin
         req = (op == OP_LW) ? S_DREQ : S_WREQ;
         for (int i = 0; i < dw && i <= TO; i++)
            add(MEM, req, 1'b0, 1'b0, rnd1(), 1'b0, rnd1(), rnd6(), rnd6());
         if (dw > TO) begin
            add_tail(ERROR);
            return;
         end
         add(MEM, req, 1'b0, 1'b0, rnd1(), 1'b1, rnd1(), rnd6(), rnd6());
         if (op == OP_SW) return;
      end
      add_n(WB, S_WB);
   endtask

   // Drive up to 'limit' planned cycles; anything beyond is discarded (reset abort).
   task automatic play(input int limit);
      cyc_t c;
      int   k;
      k = 0;
      while (plan.size() > 0) begin
         c = plan.pop_front();
         if (k < limit) begin
            @(posedge CLK);
            #1;
            RST    = c.rst;
            ihit   = c.ih;
            dhit   = c.dh;
            zero   = c.z;
            opcode = opcode_t'(c.op);
            funct  = funct_t'(c.fn);
            exp_q.push_back(c.e);
         end
         k++;
      end
   endtask

   initial begin : monitor
      logic [W-1:0] act, expv;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            act  = {dbgState, iREN, dREN, dWEN, IrWr, PcWr, PcSel, RegWr, Halt, Err,
                    RegDst, PcToReg, ImmToReg, MemToReg, ExtOp, ShamToAlu, ImmToAlu};
            n_cmp++;
            if (act !== expv) begin
               n_bad++;
               $display("FAIL cycle_outputs t=%0t got state=%0d strb=%b halt_err=%b stat=%b required state=%0d strb=%b halt_err=%b stat=%b",
                        $time, act[19:17], act[16:9], act[8:7], act[6:0],
                        expv[19:17], expv[16:9], expv[8:7], expv[6:0]);
            end
         end
      end
   end

   initial begin : stimulus
      opcode_t    ops[15];
      funct_t     fns[13];
      logic [5:0] op, fn;
      int         iw, dw;
      ops = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
              OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};
      fns = '{FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
              FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};

      add_reset(3);
      play(1000);

      // Directed instruction classes, including wait boundaries where the hit wins.
      force_ih = 1'b1;
      plan_instr(OP_ADDIU, rnd6(), 1'b0, 0, 0);
      force_ih = 1'b0;
      plan_instr(OP_LW, rnd6(), 1'b0, 0, 3);
      plan_instr(OP_BEQ, rnd6(), 1'b1, 0, 0);
      plan_instr(OP_BEQ, rnd6(), 1'b0, 0, 0);
      plan_instr(OP_BNE, rnd6(), 1'b0, 0, 0);
      plan_instr(OP_BNE, rnd6(), 1'b1, 0, 0);
      plan_instr(OP_JAL, rnd6(), 1'b0, 0, 0);
      plan_instr(OP_J, rnd6(), 1'b0, 1, 0);
      plan_instr(OP_RTYPE, FN_JR, 1'b0, 0, 0);
      plan_instr(OP_RTYPE, FN_ADDU, 1'b0, 2, 0);
      plan_instr(OP_SW, rnd6(), 1'b0, 0, 0);
      plan_instr(OP_SW, rnd6(), 1'b0, 0, TO);
      plan_instr(OP_LW, rnd6(), 1'b0, TO, TO);
      plan_instr(OP_LUI, rnd6(), 1'b0, 0, 0);
      play(1000);

      for (int n = 0; n < 80; n++) begin
         op = ops[$urandom_range(0, 14)];
         fn = (op == OP_RTYPE) ? fns[$urandom_range(0, 12)] : rnd6();
         iw = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TO) : 0;
         dw = ($urandom_range(0, 1) == 0) ? $urandom_range(0, TO) : 0;
         plan_instr(op, fn, rnd1(), iw, dw);
      end
      play(100000);

      // Reset while a load is waiting in MEM, then recover.
      plan_instr(OP_LW, rnd6(), 1'b0, 0, 3);
      play(5);
      add_reset(2);
      plan_instr(OP_ADDI, rnd6(), 1'b0, 0, 0);
      play(1000);

      plan_instr(OP_HALT, rnd6(), 1'b0, 0, 0);
      add_reset(2);
      plan_instr(OP_RTYPE, 6'b111110, 1'b0, 0, 0);
      add_reset(2);
      plan_instr(6'h3E, rnd6(), 1'b0, 0, 0);
      add_reset(2);
      plan_instr(OP_ADDIU, rnd6(), 1'b0, TO + 1, 0);
      add_reset(2);
      plan_instr(OP_SW, rnd6(), 1'b0, 0, TO + 1);
      add_reset(2);
      plan_instr(OP_ORI, rnd6(), 1'b0, 0, 0);
      play(1000);

      repeat (3) @(posedge CLK);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
